// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN          : default address/PC width (RV64)
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   OP_*          : major opcodes consumed downstream by the decoder
//   fetch_state_e : instruction fetch unit control state
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // RUN   : normal fetching under the credit limit
  // DRAIN : discarding responses still in flight from before a redirect
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with registered storage and synchronous flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO on the next edge; push/pop that cycle are ignored
//   push       : write push_data (allowed when full only together with pop)
//   pop        : advance read pointer (ignored when empty)
//   pop_data   : head entry, valid whenever empty=0
//   count      : number of stored entries (0..DEPTH)
//   full/empty : status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW + 1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word-aligned fetches to
// instruction memory and hands buffered instructions with their PCs to decode.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req_valid/ready  : fetch request channel, imem_req_addr = current PC
//   imem_resp_valid/data  : in-order response channel, never backpressured
//   inst_valid/ready      : decode channel; instruction/inst_pc are NOP/0 when idle
//   redirect_valid/pc     : single-cycle taken branch/jump, target low bits dropped
//   fetch_state           : debug view of the control state
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and once raised valid and its payload hold
// until accepted (the fetch request may only be withdrawn by a redirect).
module instruction_fetch_unit #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            instruction,
  output logic [XLEN-1:0]        inst_pc,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output riscv_pkg::fetch_state_e fetch_state
);

  import riscv_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BUF_W = XLEN + 32;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   drop_next;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_target;

  logic            req_fire;
  logic            resp_in_run;
  logic            resp_keep;

  logic [BUF_W-1:0] buf_dout;
  logic [CW-1:0]    buf_count;
  logic             buf_full;
  logic             buf_empty;
  logic [XLEN-1:0]  tag_dout;
  logic [CW-1:0]    tag_count;
  logic             tag_full;
  logic             tag_empty;
  logic             status_unused;

  // Requests in flight plus buffered instructions may never exceed the buffer
  // depth, so every response is guaranteed a slot.
  assign credit_used     = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid  = rst_n && (state == RUN) && !redirect_valid &&
                           (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // A response in RUN always retires a credit; it is only buffered when no
  // redirect is flushing the buffers in the same cycle.
  assign resp_in_run = imem_resp_valid && (state == RUN);
  assign resp_keep   = resp_in_run && !redirect_valid;
  assign out_next    = outstanding + CW'(req_fire) - CW'(resp_in_run);
  assign drop_next   = drop_cnt - CW'(imem_resp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      case (state)
        RUN: begin
          outstanding <= out_next;
          if (redirect_valid) begin
            pc          <= redirect_target;
            outstanding <= '0;
            drop_cnt    <= out_next;
            if (out_next != '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          drop_cnt <= drop_next;
          if (redirect_valid) pc <= redirect_target;
          if (drop_next == '0) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Addresses of accepted requests, consumed in order as responses return.
  inst_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_keep),
    .pop_data  (tag_dout),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Instruction buffer: {pc, instruction} presented to decode from a register.
  inst_fifo #(.WIDTH(BUF_W), .DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data ({tag_dout, imem_resp_data}),
    .pop       (inst_valid && inst_ready),
    .pop_data  (buf_dout),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign inst_valid  = !buf_empty;
  assign instruction = inst_valid ? buf_dout[31:0] : NOP_INSTR;
  assign inst_pc     = inst_valid ? buf_dout[BUF_W-1:32] : '0;
  assign fetch_state = state;

  assign status_unused = ^{tag_count, tag_full, tag_empty, buf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam int          W        = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_state_e fetch_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_state     (fetch_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: three real instructions at the bottom, an address hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00730233;
      64'h4:   return 32'h40b504b3;
      64'h8:   return 32'h00e6f633;
      default: return a[31:0] ^ 32'h5a5a0003;
    endcase
  endfunction

  // ---------------- memory model ----------------
  // Inputs are driven at the falling edge; the request handshake is judged just
  // before the following rising edge.
  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc = 0;
  int          last_due = 0;
  int          mem_due;
  int          acc_count = 0;
  logic [63:0] last_acc_addr = '0;
  bit          ready_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    imem_req_ready = ready_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
    #4;
    if (!rst_n) begin
      pend_q.delete();
      last_due = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_due = cyc + $urandom_range(lat_max, lat_min);
      if (mem_due <= last_due) mem_due = last_due + 1;
      last_due = mem_due;
      pend_q.push_back('{addr: imem_req_addr, due: mem_due});
      acc_count++;
      last_acc_addr = imem_req_addr;
      check("in_flight_limit", 64'(pend_q.size() + (imem_resp_valid ? 1 : 0) <= DEPTH), 64'd1);
    end
  end

  // ---------------- scoreboard / model ----------------
  // Decode must see one unbroken stream of words starting at the last reset or
  // redirect target, each word tagged with its address; fetches follow the same
  // rule on the request side.
  logic [63:0] exp_pc    = RESET_PC;
  logic [63:0] exp_fetch = RESET_PC;
  int          pop_count = 0;
  bit          stalled   = 1'b0;
  logic [63:0] stall_addr = '0;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
      stalled   = 1'b0;
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_instruction", 64'(instruction), 64'(NOP_INSTR));
      check("rst_inst_pc", inst_pc, 64'd0);
    end else begin
      if (!inst_valid) begin
        check("idle_instruction", 64'(instruction), 64'(NOP_INSTR));
        check("idle_inst_pc", inst_pc, 64'd0);
      end else if (inst_ready) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", 64'(instruction), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        pop_count++;
      end
      if (stalled && !redirect_valid) begin
        check("req_hold_valid", 64'(imem_req_valid), 64'd1);
        check("req_hold_addr", imem_req_addr, stall_addr);
      end
      check("req_addr_align", 64'(imem_req_addr[1:0]), 64'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 64'd4;
      end
      if (redirect_valid) begin
        check("req_during_redirect", 64'(imem_req_valid), 64'd0);
        exp_pc    = {redirect_pc[63:2], 2'b00};
        exp_fetch = {redirect_pc[63:2], 2'b00};
      end
      stalled    = imem_req_valid && !imem_req_ready;
      stall_addr = imem_req_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    acc_count = 0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  task automatic wait_accept(input string name, input int budget, output logic [63:0] addr);
    int start;
    bit got;
    start = acc_count;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (acc_count != start) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_accept_seen"}, 64'(got), 64'd1);
    addr = last_acc_addr;
  endtask

  task automatic wait_pop(input string name, input int budget,
                          output logic [63:0] pc, output logic [31:0] data);
    bit got;
    got  = 1'b0;
    pc   = '0;
    data = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (inst_valid && inst_ready) begin
        got  = 1'b1;
        pc   = inst_pc;
        data = instruction;
        break;
      end
    end
    check({name, "_pop_seen"}, 64'(got), 64'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [W-1:0] exp_q[$];
  logic [63:0]  got_addr;
  logic [63:0]  got_pc;
  logic [31:0]  got_data;
  int           rand_start;

  initial begin
    rst_n          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1 rst_n = 1'b0;

    // 1: straight-line fetch, 1-cycle memory, decode always ready.
    lat_min = 1; lat_max = 1; ready_rand = 1'b0; inst_ready = 1'b1;
    do_reset();
    #2 check("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
    check("t1_first_req_addr", imem_req_addr, 64'h0);
    @(negedge clk); #2;
    check("t1_cycle2_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk); #2;
    check("t1_cycle3_inst_valid", 64'(inst_valid), 64'd1);
    check("t1_cycle3_inst_pc", inst_pc, 64'h0);
    check("t1_cycle3_instruction", 64'(instruction), 64'h00730233);
    exp_q = '{64'h4, 64'h8};
    wait_pop("t1_second", 10, got_pc, got_data);
    check("t1_second_pc", got_pc, exp_q.pop_front());
    check("t1_second_data", 64'(got_data), 64'h40b504b3);
    wait_pop("t1_third", 10, got_pc, got_data);
    check("t1_third_pc", got_pc, exp_q.pop_front());
    check("t1_third_data", 64'(got_data), 64'h00e6f633);

    // 2: decode stalled for 10 cycles -> only DEPTH requests go out.
    inst_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    #2 check("t2_req_count", 64'(acc_count), 64'd2);
    check("t2_req_valid_off", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    inst_ready = 1'b1;
    wait_accept("t2_resume", 10, got_addr);
    check("t2_resume_addr", got_addr, 64'h8);

    // 3: redirect with two requests in flight -> drain, then fetch at 0x100.
    lat_min = 4; lat_max = 4; inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    pulse_redirect(64'h100);
    #2 check("t3_outstanding_before", 64'(acc_count), 64'd2);
    check("t3_req_blocked", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2 check("t3_state_drain", 64'(fetch_state), 64'(DRAIN));
    check("t3_no_req_in_drain", 64'(imem_req_valid), 64'd0);
    wait_accept("t3_after_drain", 20, got_addr);
    check("t3_next_addr", got_addr, 64'h100);
    wait_pop("t3_first", 20, got_pc, got_data);
    check("t3_first_pc", got_pc, 64'h100);
    check("t3_first_data", 64'(got_data), 64'h5a5a0103);

    // 4: misaligned target, plus a second redirect while draining.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    pulse_redirect(64'h300);
    @(negedge clk);
    pulse_redirect(64'h203);
    #2 check("t4_state_drain", 64'(fetch_state), 64'(DRAIN));
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_accept("t4_after_drain", 20, got_addr);
    check("t4_aligned_addr", got_addr, 64'h200);
    wait_pop("t4_first", 20, got_pc, got_data);
    check("t4_first_pc", got_pc, 64'h200);
    check("t4_first_data", 64'(got_data), 64'h5a5a0203);
    check("t4_state_run", 64'(fetch_state), 64'(RUN));

    // 6: reset while draining with responses pending.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    pulse_redirect(64'h100);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t6_pre_state_drain", 64'(fetch_state), 64'(DRAIN));
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_async_req_addr", imem_req_addr, RESET_PC);
    check("t6_async_inst_valid", 64'(inst_valid), 64'd0);
    check("t6_async_instruction", 64'(instruction), 64'(NOP_INSTR));
    check("t6_async_state", 64'(fetch_state), 64'(RUN));
    repeat (2) @(negedge clk);
    acc_count = 0;
    rst_n = 1'b1;
    #2 check("t6_release_req_valid", 64'(imem_req_valid), 64'd1);
    check("t6_release_req_addr", imem_req_addr, RESET_PC);
    wait_pop("t6_first", 20, got_pc, got_data);
    check("t6_first_pc", got_pc, RESET_PC);
    check("t6_first_data", 64'(got_data), 64'h00730233);

    // 5: random memory readiness/latency and decode backpressure, rare redirects.
    lat_min = 1; lat_max = 4; ready_rand = 1'b1;
    do_reset();
    rand_start = pop_count;
    for (int c = 0; c < 4000 && (pop_count - rand_start) < 200; c++) begin
      @(negedge clk);
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) pulse_redirect(64'($urandom_range(16'hffff, 0)));
      else redirect_valid = 1'b0;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t5_pops_200", 64'((pop_count - rand_start) >= 200), 64'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the instruction interface consumed by InstructionDecoder/ControlUnit.
- Holds the PC and issues word-aligned fetch requests to instruction memory using a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered instructions and discarding in-flight responses.

Parameters:
- XLEN, 64, PC/address width (RV64: ld/sd supported downstream).
- RESET_PC, 64'h0, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the outstanding-request credit limit (power of 2, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, bits[1:0] always 0.
- imem_resp_valid  in  1  response valid (in order, ≥1 cycle after acceptance, never backpressured).
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- instruction  out  32  instruction to decoder; 32'h00000013 (NOP) when inst_valid=0.
- inst_pc  out  XLEN  PC of presented instruction; 0 when inst_valid=0.
- redirect_valid  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  XLEN  new PC; bits[1:0] ignored (forced 0).

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=RUN, outstanding=0, drop_cnt=0, FIFO empty; imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, instruction=NOP, inst_pc=0. First request is issued on the first cycle after release.
- Credit: imem_req_valid=1 only in RUN when outstanding+fifo_count < FIFO_DEPTH and no redirect this cycle. Request accepted on valid&ready: outstanding+1, pc+=4 (XLEN wrap). imem_req_addr=pc combinationally.
- Response in RUN: push {pc_tag, data} into FIFO, outstanding-1. pc_tag comes from an internal in-order tag queue of issued addresses (depth FIFO_DEPTH).
- Decode side: inst_valid = !fifo_empty; pop on inst_valid&inst_ready. Latency from request acceptance to inst_valid is 1 cycle after imem_resp_valid (registered FIFO output).
- Simultaneous push and pop on a full FIFO is legal. The credit rule guarantees pushes never overflow; overflow is an assertion failure.
- States: RUN, DRAIN.
  - RUN→DRAIN: redirect_valid while outstanding (after this cycle's accept/response updates) > 0. drop_cnt := that count.
  - RUN→RUN: redirect with outstanding = 0.
  - DRAIN: no requests; each response decrements drop_cnt and is discarded. At drop_cnt = 0 (same-cycle response included), go to RUN and issue next cycle.
- Any redirect: pc := {redirect_pc[XLEN-1:2], 2'b00}; FIFO and tag queue flushed. A pop completing in the redirect cycle counts as consumed. A response arriving in the redirect cycle is dropped. A request accepted in the redirect cycle counts toward drop_cnt.
- Redirect during DRAIN: updates pc only; drop_cnt keeps counting down.
- imem_req_valid may drop without acceptance only on redirect; otherwise it is held with a stable address until ready.

Decomposition:
- riscv_pkg: XLEN, NOP_INSTR=32'h00000013, opcode constants (OP_R=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011), fetch state enum {RUN, DRAIN}.
- Sub-module inst_fifo: synchronous FIFO, parameterised width/depth, with synchronous flush, count, full/empty. Instanced twice: instruction+PC buffer and address tag queue.

Test Plan:
- Reset, imem always ready, 1-cycle response of 32'h00730233, 32'h40b504b3, 32'h00e6f633, inst_ready=1 → instructions appear in order with inst_pc 0x0, 0x4, 0x8; inst_valid first high on cycle 3 after reset release.
- inst_ready=0 held for 10 cycles → exactly FIFO_DEPTH (2) requests issued, then imem_req_valid=0; on ready release, requests resume at 0x8.
- Redirect to 0x100 while 2 requests are outstanding → state DRAIN, both responses discarded, next request addr 0x100, first inst_pc 0x100 with no stale instruction visible.
- Redirect_pc=0x203 → fetch address 0x200.
- imem_req_ready random 50%, response latency 1–4 cycles, 200 instructions → no loss or duplication, inst_pc increments by 4, FIFO never overflows.
- Reset asserted mid-DRAIN with a response pending → outputs return to reset values immediately; post-release first request addr is RESET_PC.
